// File: rtl/branch_operand_fwd_if.sv
// Signal bundle between the pipeline (master) and the branch operand forwarding unit (slave).
interface branch_operand_fwd_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RAW   = 5,
  parameter int unsigned CNT_W = 16
);
  logic            id_valid;
  logic [RAW-1:0]  id_rs1;
  logic [RAW-1:0]  id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;
  logic            ex_valid;
  logic            ex_we;
  logic            ex_is_load;
  logic [RAW-1:0]  ex_rd;
  logic [XLEN-1:0] ex_result;
  logic            mem_valid;
  logic            mem_we;
  logic            mem_is_load;
  logic            mem_rvalid;
  logic [RAW-1:0]  mem_rd;
  logic [XLEN-1:0] mem_result;
  logic            wb_we;
  logic [RAW-1:0]  wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] rdata_FA;
  logic [XLEN-1:0] rdata_FB;
  logic            Stall;
  logic [1:0]      stall_state;
  logic [CNT_W-1:0] stall_cnt;
  logic            mem_timeout;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, rf_rdata1, rf_rdata2,
           ex_valid, ex_we, ex_is_load, ex_rd, ex_result,
           mem_valid, mem_we, mem_is_load, mem_rvalid, mem_rd, mem_result,
           wb_we, wb_rd, wb_data,
    input  rdata_FA, rdata_FB, Stall, stall_state, stall_cnt, mem_timeout
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, rf_rdata1, rf_rdata2,
           ex_valid, ex_we, ex_is_load, ex_rd, ex_result,
           mem_valid, mem_we, mem_is_load, mem_rvalid, mem_rd, mem_result,
           wb_we, wb_rd, wb_data,
    output rdata_FA, rdata_FB, Stall, stall_state, stall_cnt, mem_timeout
  );
endinterface

// File: rtl/branch_operand_fwd.sv
// Operand forwarding and load hazard detection for the branch operand register stage,
// with stall-episode FSM, memory-wait watchdog and saturating stall counter.
module branch_operand_fwd #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RAW     = 5,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  branch_operand_fwd_if.slave bus
);

  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO_W = WW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_LU  = 2'd1,
    ST_MW  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             timeout_q, timeout_d;

  logic             need_a, need_b;
  logic             ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
  logic             mem_ready;
  logic             haz_lu, haz_mw, stall;

  function automatic logic [XLEN-1:0] pick(
    input logic            need,
    input logic            m_ex,
    input logic            m_mem,
    input logic            m_wb,
    input logic            ex_ld,
    input logic            mem_rdy,
    input logic [XLEN-1:0] ex_res,
    input logic [XLEN-1:0] mem_res,
    input logic [XLEN-1:0] wb_res,
    input logic [XLEN-1:0] rf_res
  );
    if (!need)                 return '0;
    else if (m_ex && !ex_ld)   return ex_res;
    else if (m_mem && mem_rdy) return mem_res;
    else if (m_wb)             return wb_res;
    else                       return rf_res;
  endfunction

  // x0 is never a real dependency, so a zero index masks every match.
  assign need_a = bus.id_use_rs1 && (bus.id_rs1 != '0);
  assign need_b = bus.id_use_rs2 && (bus.id_rs2 != '0);

  assign ex_a  = bus.ex_valid && bus.ex_we && (bus.ex_rd == bus.id_rs1);
  assign ex_b  = bus.ex_valid && bus.ex_we && (bus.ex_rd == bus.id_rs2);
  assign mem_a = bus.mem_valid && bus.mem_we && (bus.mem_rd == bus.id_rs1);
  assign mem_b = bus.mem_valid && bus.mem_we && (bus.mem_rd == bus.id_rs2);
  assign wb_a  = bus.wb_we && (bus.wb_rd == bus.id_rs1);
  assign wb_b  = bus.wb_we && (bus.wb_rd == bus.id_rs2);

  assign mem_ready = !bus.mem_is_load || bus.mem_rvalid;

  assign haz_lu = bus.id_valid && bus.ex_is_load &&
                  ((need_a && ex_a) || (need_b && ex_b));
  assign haz_mw = bus.id_valid && bus.mem_is_load && !bus.mem_rvalid &&
                  ((need_a && mem_a) || (need_b && mem_b));
  assign stall  = !rst && (haz_lu || haz_mw);

  always_comb begin
    bus.rdata_FA = '0;
    bus.rdata_FB = '0;
    if (!rst) begin
      bus.rdata_FA = pick(need_a, ex_a, mem_a, wb_a, bus.ex_is_load, mem_ready,
                          bus.ex_result, bus.mem_result, bus.wb_data, bus.rf_rdata1);
      bus.rdata_FB = pick(need_b, ex_b, mem_b, wb_b, bus.ex_is_load, mem_ready,
                          bus.ex_result, bus.mem_result, bus.wb_data, bus.rf_rdata2);
    end
  end

  always_comb begin
    state_d     = ST_RUN;
    wait_cnt_d  = '0;
    stall_cnt_d = stall_cnt_q;
    timeout_d   = timeout_q;
    if (haz_mw)      state_d = ST_MW;
    else if (haz_lu) state_d = ST_LU;
    if (state_d == ST_MW)
      wait_cnt_d = (wait_cnt_q == TO_W) ? wait_cnt_q : wait_cnt_q + 1'b1;
    // Sticky flag observes the post-edge count so it rises with the final wait cycle.
    if (wait_cnt_d == TO_W) timeout_d = 1'b1;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.Stall       = stall;
  assign bus.stall_state = state_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.mem_timeout = timeout_q;

endmodule

// File: tb/tb_branch_operand_fwd.sv
// Directed bench for branch_operand_fwd with a per-cycle reference model and literal spot checks.
module tb_branch_operand_fwd;
  localparam int unsigned CW = 4;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  branch_operand_fwd_if #(.XLEN(32), .RAW(5), .CNT_W(CW)) bus ();
  branch_operand_fwd #(.XLEN(32), .RAW(5), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference: youngest producer whose value is ready supplies the operand.
  function automatic logic [31:0] model_op(input logic [4:0] rs, input logic use_rs,
                                           input logic [31:0] rf);
    logic        hit[3];
    logic        rdy[3];
    logic [31:0] val[3];
    if (!use_rs || rs == 5'd0) return 32'd0;
    hit[0] = bus.ex_valid && bus.ex_we && bus.ex_rd == rs;
    rdy[0] = !bus.ex_is_load;
    val[0] = bus.ex_result;
    hit[1] = bus.mem_valid && bus.mem_we && bus.mem_rd == rs;
    rdy[1] = !bus.mem_is_load || bus.mem_rvalid;
    val[1] = bus.mem_result;
    hit[2] = bus.wb_we && bus.wb_rd == rs;
    rdy[2] = 1'b1;
    val[2] = bus.wb_data;
    for (int i = 0; i < 3; i++) if (hit[i] && rdy[i]) return val[i];
    return rf;
  endfunction

  function automatic logic waits_ex(input logic [4:0] rs, input logic use_rs);
    return bus.id_valid && use_rs && rs != 5'd0 && bus.ex_valid && bus.ex_we &&
           bus.ex_rd == rs && bus.ex_is_load;
  endfunction

  function automatic logic waits_mem(input logic [4:0] rs, input logic use_rs);
    return bus.id_valid && use_rs && rs != 5'd0 && bus.mem_valid && bus.mem_we &&
           bus.mem_rd == rs && bus.mem_is_load && !bus.mem_rvalid;
  endfunction

  int unsigned m_state = 0;
  int unsigned m_wait = 0;
  int unsigned m_cnt = 0;
  logic        m_to = 1'b0;

  always @(negedge clk) begin
    logic lu, mw, st;
    lu = waits_ex(bus.id_rs1, bus.id_use_rs1) || waits_ex(bus.id_rs2, bus.id_use_rs2);
    mw = waits_mem(bus.id_rs1, bus.id_use_rs1) || waits_mem(bus.id_rs2, bus.id_use_rs2);
    st = !rst && (lu || mw);
    chk("m_state", 32'(bus.stall_state), m_state);
    chk("m_cnt", 32'(bus.stall_cnt), m_cnt);
    chk("m_timeout", 32'(bus.mem_timeout), 32'(m_to));
    chk("m_stall", 32'(bus.Stall), 32'(st));
    if (!st) begin
      chk("m_FA", bus.rdata_FA, rst ? 32'd0 : model_op(bus.id_rs1, bus.id_use_rs1, bus.rf_rdata1));
      chk("m_FB", bus.rdata_FB, rst ? 32'd0 : model_op(bus.id_rs2, bus.id_use_rs2, bus.rf_rdata2));
    end
    if (rst) begin
      m_state = 0; m_wait = 0; m_cnt = 0; m_to = 1'b0;
    end else begin
      m_state = mw ? 2 : (lu ? 1 : 0);
      m_wait  = mw ? ((m_wait < TO) ? m_wait + 1 : TO) : 0;
      if (m_wait >= TO) m_to = 1'b1;
      if (st && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 1'b0; bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
    bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
    bus.rf_rdata1 = 32'hAAAA0001; bus.rf_rdata2 = 32'hBBBB0002;
    bus.ex_valid = 1'b0; bus.ex_we = 1'b0; bus.ex_is_load = 1'b0;
    bus.ex_rd = 5'd0; bus.ex_result = 32'd0;
    bus.mem_valid = 1'b0; bus.mem_we = 1'b0; bus.mem_is_load = 1'b0;
    bus.mem_rvalid = 1'b0; bus.mem_rd = 5'd0; bus.mem_result = 32'd0;
    bus.wb_we = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
  endtask

  task automatic id_both(input logic [4:0] r1, input logic [4:0] r2);
    bus.id_valid = 1'b1; bus.id_rs1 = r1; bus.id_rs2 = r2;
    bus.id_use_rs1 = 1'b1; bus.id_use_rs2 = 1'b1;
  endtask

  task automatic ex_wr(input logic [4:0] rd, input logic ld, input logic [31:0] v);
    bus.ex_valid = 1'b1; bus.ex_we = 1'b1; bus.ex_is_load = ld;
    bus.ex_rd = rd; bus.ex_result = v;
  endtask

  task automatic mem_wr(input logic [4:0] rd, input logic ld, input logic rv,
                        input logic [31:0] v);
    bus.mem_valid = 1'b1; bus.mem_we = 1'b1; bus.mem_is_load = ld;
    bus.mem_rvalid = rv; bus.mem_rd = rd; bus.mem_result = v;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    id_both(5'd5, 5'd5);
    ex_wr(5'd5, 1'b1, 32'hDEADBEEF);
    #1;
    chk("rst_stall", 32'(bus.Stall), 32'd0);
    chk("rst_FA", bus.rdata_FA, 32'd0);
    cyc(); cyc();
    chk("rst_state", 32'(bus.stall_state), 32'd0);
    chk("rst_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rst_timeout", 32'(bus.mem_timeout), 32'd0);
    rst = 1'b0;
    idle();

    // EX ALU forward on A, B from register file
    id_both(5'd5, 5'd9);
    ex_wr(5'd5, 1'b0, 32'hDEADBEEF);
    #1;
    chk("t1_FA", bus.rdata_FA, 32'hDEADBEEF);
    chk("t1_FB", bus.rdata_FB, 32'hBBBB0002);
    chk("t1_stall", 32'(bus.Stall), 32'd0);
    cyc();

    // x0 never forwards
    id_both(5'd5, 5'd0);
    ex_wr(5'd0, 1'b0, 32'h55);
    #1;
    chk("t2_FB", bus.rdata_FB, 32'd0);
    cyc();

    // EX > MEM > WB priority, peeled off one stage at a time
    idle();
    id_both(5'd4, 5'd3);
    ex_wr(5'd3, 1'b0, 32'h11);
    mem_wr(5'd3, 1'b0, 1'b0, 32'h22);
    bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h33;
    #1; chk("t3_ex", bus.rdata_FB, 32'h11); cyc();
    bus.ex_valid = 1'b0;
    #1; chk("t3_mem", bus.rdata_FB, 32'h22); cyc();
    bus.mem_valid = 1'b0;
    #1; chk("t3_wb", bus.rdata_FB, 32'h33); cyc();
    bus.wb_we = 1'b0;
    #1; chk("t3_rf", bus.rdata_FB, 32'hBBBB0002); cyc();
    bus.id_use_rs2 = 1'b0; bus.wb_we = 1'b1;
    #1; chk("t3_unused", bus.rdata_FB, 32'd0); cyc();

    // Load-use, data returns in first MEM cycle
    idle();
    id_both(5'd1, 5'd7);
    ex_wr(5'd7, 1'b1, 32'h0);
    #1; chk("t4_stall", 32'(bus.Stall), 32'd1);
    cyc();
    chk("t4_state", 32'(bus.stall_state), 32'd1);
    bus.ex_valid = 1'b0;
    mem_wr(5'd7, 1'b1, 1'b1, 32'h1234);
    #1;
    chk("t4_stall_rel", 32'(bus.Stall), 32'd0);
    chk("t4_FB", bus.rdata_FB, 32'h1234);
    chk("t4_cnt", 32'(bus.stall_cnt), 32'd1);
    cyc();
    idle(); cyc();

    // Load-use with three memory-wait cycles
    id_both(5'd1, 5'd7);
    ex_wr(5'd7, 1'b1, 32'h0);
    cyc();
    bus.ex_valid = 1'b0;
    mem_wr(5'd7, 1'b1, 1'b0, 32'h0);
    cyc();
    chk("t5_state_mw", 32'(bus.stall_state), 32'd2);
    chk("t5_stall", 32'(bus.Stall), 32'd1);
    cyc(); cyc();
    bus.mem_rvalid = 1'b1; bus.mem_result = 32'hCAFE0005;
    #1;
    chk("t5_stall_rel", 32'(bus.Stall), 32'd0);
    chk("t5_FB", bus.rdata_FB, 32'hCAFE0005);
    chk("t5_cnt", 32'(bus.stall_cnt), 32'd5);
    cyc();

    // EX and MEM hazards on different operands: MW wins
    idle();
    id_both(5'd7, 5'd8);
    ex_wr(5'd7, 1'b1, 32'h0);
    mem_wr(5'd8, 1'b1, 1'b0, 32'h0);
    cyc();
    chk("t5b_state", 32'(bus.stall_state), 32'd2);
    idle(); cyc();

    // Watchdog: memory never answers
    id_both(5'd1, 5'd7);
    ex_wr(5'd7, 1'b1, 32'h0);
    cyc();
    bus.ex_valid = 1'b0;
    mem_wr(5'd7, 1'b1, 1'b0, 32'h0);
    cyc(); cyc(); cyc();
    chk("t6_to_early", 32'(bus.mem_timeout), 32'd0);
    cyc();
    chk("t6_timeout", 32'(bus.mem_timeout), 32'd1);
    chk("t6_stall_held", 32'(bus.Stall), 32'd1);
    cyc();
    chk("t6_sticky", 32'(bus.mem_timeout), 32'd1);
    rst = 1'b1;
    #1; chk("t6_rst_stall", 32'(bus.Stall), 32'd0);
    cyc();
    chk("t6_rst_state", 32'(bus.stall_state), 32'd0);
    chk("t6_rst_to", 32'(bus.mem_timeout), 32'd0);
    chk("t6_rst_cnt", 32'(bus.stall_cnt), 32'd0);
    rst = 1'b0;
    idle(); cyc();

    // Counter saturation under a held load-use stall
    id_both(5'd7, 5'd2);
    ex_wr(5'd7, 1'b1, 32'h0);
    for (int i = 0; i < 20; i++) cyc();
    chk("sat_cnt", 32'(bus.stall_cnt), 32'd15);
    chk("sat_state", 32'(bus.stall_state), 32'd1);
    idle(); cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
